// File: rtl/mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer_pkg
// Purpose  : Shared types for the MAC sequencer: accumulator control codes,
//            sequencer states and the alignment-slot decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package mac_sequencer_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;

   // Accumulator control codes; the accumulator treats any unknown code as MAC.
   typedef enum logic [1:0] {
      ACC_MAC        = 2'b00,
      ACC_LOAD       = 2'b01,
      ACC_HOLD       = 2'b10,
      ACC_COMPLEMENT = 2'b11
   } acc_ctrl_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_DRAIN = 3'd2,
      S_NEG   = 3'd3,
      S_OUT   = 3'd4
   } seq_state_e;

   // A product slot arriving at the accumulator: empty slots hold, the first
   // term of a job loads, every later term accumulates.
   function automatic acc_ctrl_e slot_ctrl(input logic valid, input logic first);
      if (!valid) begin
         return ACC_HOLD;
      end else if (first) begin
         return ACC_LOAD;
      end else begin
         return ACC_MAC;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_sequencer_align_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_align_pipe
// Purpose  : MUL_LAT-deep {valid, first} shift register that delays each
//            issued term so its accumulator control lines up with the
//            product leaving the multiplier pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mac_align_pipe
   import mac_sequencer_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       in_valid,
   input  logic       in_first,
   output logic [1:0] acc_ctrl,
   output logic       empty,
   output logic       ending
);

   logic [MUL_LAT-1:0] valid_q, valid_d;
   logic [MUL_LAT-1:0] first_q, first_d;
   logic               upstream_busy;

   // Shift one slot per cycle; the tail slot is the one the accumulator sees.
   always_comb begin
      valid_d    = valid_q;
      first_d    = first_q;
      valid_d[0] = in_valid;
      first_d[0] = in_valid & in_first;
      for (int i = 1; i < MUL_LAT; i++) begin
         valid_d[i] = valid_q[i-1];
         first_d[i] = first_q[i-1];
      end
   end

   // Pipe registers, cleared by reset so an aborted job leaves nothing behind.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         first_q <= '0;
      end else begin
         valid_q <= valid_d;
         first_q <= first_d;
      end
   end

   // ending: the tail holds the final term and nothing follows it, so the
   // accumulator's last data update happens at the end of this cycle.
   always_comb begin
      upstream_busy = 1'b0;
      for (int i = 0; i < MUL_LAT - 1; i++) begin
         upstream_busy = upstream_busy | valid_q[i];
      end
      empty    = ~|valid_q;
      ending   = valid_q[MUL_LAT-1] & ~upstream_busy;
      acc_ctrl = slot_ctrl(valid_q[MUL_LAT-1], first_q[MUL_LAT-1]);
   end

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer
// Purpose  : Runs one dot-product job: issues operand addresses, steers the
//            accumulator through the multiplier latency, optionally negates
//            the sum and hands the captured result over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int ADDR_WIDTH = 9,
   parameter int LEN_WIDTH  = 6,
   parameter int MUL_LAT    = 2
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [ADDR_WIDTH-1:0] base_a,
   input  logic [ADDR_WIDTH-1:0] base_b,
   input  logic                  negate,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [1:0]            acc_ctrl,
   input  logic [DATA_WIDTH-1:0] acc_out,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid,
   input  logic                  result_ready
);

   seq_state_e            state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic                  first_q, first_d;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
   logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
   logic [LEN_WIDTH-1:0]  remain_q, remain_d;
   logic                  negate_q, negate_d;
   logic                  zero_len_q, zero_len_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  result_valid_q, result_valid_d;

   logic [1:0]            pipe_ctrl;
   logic                  pipe_empty;
   logic                  pipe_ending;

   mac_align_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_align_pipe (
      .clock    (clock),
      .resetn   (resetn),
      .in_valid (rd_en_q),
      .in_first (first_q),
      .acc_ctrl (pipe_ctrl),
      .empty    (pipe_empty),
      .ending   (pipe_ending)
   );

   // Next-state and output decode for the job sequencer.
   // The complement is issued in the cycle right after the last MAC so the
   // negated sum has a full cycle to settle in the accumulator; the sequencer
   // then returns to DRAIN for that settle cycle before capturing.
   always_comb begin
      state_d        = state_q;
      rd_en_d        = rd_en_q;
      first_d        = first_q;
      addr_a_d       = addr_a_q;
      addr_b_d       = addr_b_q;
      remain_d       = remain_q;
      negate_d       = negate_q;
      zero_len_d     = zero_len_q;
      busy_d         = busy_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d     = 1'b1;
               zero_len_d = (len == '0);
               negate_d   = negate & (len != '0);
               if (len != '0) begin
                  state_d  = S_ISSUE;
                  rd_en_d  = 1'b1;
                  first_d  = 1'b1;
                  addr_a_d = base_a;
                  addr_b_d = base_b;
                  remain_d = len - LEN_WIDTH'(1);
               end else begin
                  // Empty job: skip issue, settle one cycle, report zero.
                  state_d = S_DRAIN;
               end
            end
         end
         S_ISSUE: begin
            first_d = 1'b0;
            if (remain_q == '0) begin
               rd_en_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               addr_a_d = addr_a_q + ADDR_WIDTH'(1);
               addr_b_d = addr_b_q + ADDR_WIDTH'(1);
               remain_d = remain_q - LEN_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (negate_q && pipe_ending) begin
               state_d  = S_NEG;
               negate_d = 1'b0;
            end else if (pipe_empty) begin
               state_d        = S_OUT;
               result_d       = zero_len_q ? '0 : acc_out;
               result_valid_d = 1'b1;
            end
         end
         S_NEG: begin
            state_d = S_DRAIN;
         end
         S_OUT: begin
            if (result_ready) begin
               state_d        = S_IDLE;
               result_valid_d = 1'b0;
               busy_d         = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer state and registered outputs; reset aborts any job in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         rd_en_q        <= 1'b0;
         first_q        <= 1'b0;
         addr_a_q       <= '0;
         addr_b_q       <= '0;
         remain_q       <= '0;
         negate_q       <= 1'b0;
         zero_len_q     <= 1'b0;
         busy_q         <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_en_q        <= rd_en_d;
         first_q        <= first_d;
         addr_a_q       <= addr_a_d;
         addr_b_q       <= addr_b_d;
         remain_q       <= remain_d;
         negate_q       <= negate_d;
         zero_len_q     <= zero_len_d;
         busy_q         <= busy_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign rd_en        = rd_en_q;
   assign addr_a       = addr_a_q;
   assign addr_b       = addr_b_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign acc_ctrl     = (state_q == S_NEG) ? ACC_COMPLEMENT : pipe_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_sequencer
// Purpose  : Bench for mac_sequencer with behavioural operand memories, a
//            two-stage multiplier and a registered accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

   localparam int MUL_LAT = 2;
   localparam logic [1:0] C_MAC  = 2'b00;
   localparam logic [1:0] C_LOAD = 2'b01;
   localparam logic [1:0] C_HOLD = 2'b10;
   localparam logic [1:0] C_COMP = 2'b11;

   logic        clock;
   logic        resetn;
   logic        start;
   logic [5:0]  len;
   logic [8:0]  base_a;
   logic [8:0]  base_b;
   logic        negate;
   logic        rd_en;
   logic [8:0]  addr_a;
   logic [8:0]  addr_b;
   logic [1:0]  acc_ctrl;
   logic [31:0] acc_out;
   logic        busy;
   logic [31:0] result;
   logic        result_valid;
   logic        result_ready;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   logic [31:0] mem_a [512];
   logic [31:0] mem_b [512];
   logic [31:0] rdata_a_q, rdata_b_q, prod_q, acc_q;

   mac_sequencer #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (9),
      .LEN_WIDTH  (6),
      .MUL_LAT    (MUL_LAT)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .start        (start),
      .len          (len),
      .base_a       (base_a),
      .base_b       (base_b),
      .negate       (negate),
      .rd_en        (rd_en),
      .addr_a       (addr_a),
      .addr_b       (addr_b),
      .acc_ctrl     (acc_ctrl),
      .acc_out      (acc_out),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Memory read (1 cycle) + multiply register (1 cycle) = MUL_LAT of 2,
   // followed by the accumulator register sharing the sequencer reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         prod_q    <= '0;
         acc_q     <= '0;
      end else begin
         if (rd_en) begin
            rdata_a_q <= mem_a[addr_a];
            rdata_b_q <= mem_b[addr_b];
         end
         prod_q <= rdata_a_q * rdata_b_q;
         case (acc_ctrl)
            C_LOAD:  acc_q <= prod_q;
            C_HOLD:  acc_q <= acc_q;
            C_COMP:  acc_q <= -acc_q;
            default: acc_q <= acc_q + prod_q;
         endcase
      end
   end
   assign acc_out = acc_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every accepted result is matched against the queue.
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", result, 32'hDEAD_BEEF);
            end else begin
               check("scoreboard_result", result, exp_q.pop_front());
            end
         end
      end
   end

   // Issue one job and follow it cycle by cycle until its result is taken.
   task automatic run_job(input int n, input logic [8:0] ba, input logic [8:0] bb,
                          input logic neg, input logic [31:0] exp_res,
                          input int ready_wait, input bit poke_start);
      int         exp_vc;
      int         valid_cyc;
      bit         done;
      logic [1:0] ec;
      logic [8:0] ea;
      logic [8:0] eb;
      exp_vc    = (n == 0) ? 1 : n + MUL_LAT + 1 + (neg ? 1 : 0);
      valid_cyc = -1;
      done      = 1'b0;
      @(negedge clock);
      start        = 1'b1;
      len          = 6'(n);
      base_a       = ba;
      base_b       = bb;
      negate       = neg;
      result_ready = 1'b0;
      exp_q.push_back(exp_res);
      @(posedge clock);
      #1;
      start  = 1'b0;
      len    = 6'h3f;
      base_a = ~ba;
      base_b = ~bb;
      negate = ~neg;
      for (int c = 0; c < 80 && !done; c++) begin
         @(negedge clock);
         ec = C_HOLD;
         if (n > 0 && c == MUL_LAT) ec = C_LOAD;
         else if (n > 0 && c > MUL_LAT && c < n + MUL_LAT) ec = C_MAC;
         else if (n > 0 && neg && c == n + MUL_LAT) ec = C_COMP;
         check("acc_ctrl", 32'(acc_ctrl), 32'(ec));
         check("rd_en", 32'(rd_en), (c < n) ? 32'd1 : 32'd0);
         if (c < n) begin
            ea = ba + 9'(c);
            eb = bb + 9'(c);
            check("addr_a", 32'(addr_a), 32'(ea));
            check("addr_b", 32'(addr_b), 32'(eb));
         end
         check("busy", 32'(busy), 32'd1);
         if (valid_cyc < 0 && result_valid) begin
            valid_cyc = c;
            check("valid_rise_cycle", 32'(c), 32'(exp_vc));
         end
         if (valid_cyc >= 0) begin
            check("result_valid_hold", 32'(result_valid), 32'd1);
            check("result_hold", result, exp_res);
            if (poke_start) start = 1'b1;
            if (c - valid_cyc >= ready_wait) begin
               result_ready = 1'b1;
               done         = 1'b1;
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL job_timeout: result_valid=%0b expected 1 within 80 cycles", result_valid);
      end
      @(posedge clock);
      @(negedge clock);
      result_ready = 1'b0;
      start        = 1'b0;
      check("busy_after", 32'(busy), 32'd0);
      check("valid_after", 32'(result_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      check({tag, "_addr_a"}, 32'(addr_a), 32'd0);
      check({tag, "_addr_b"}, 32'(addr_b), 32'd0);
      check({tag, "_acc_ctrl"}, 32'(acc_ctrl), 32'(C_HOLD));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_result"}, result, 32'd0);
      check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
   endtask

   // Start a len=4 job and pull reset in its second issue cycle.
   task automatic reset_mid_job();
      @(negedge clock);
      start  = 1'b1;
      len    = 6'd4;
      base_a = 9'd0;
      base_b = 9'd0;
      negate = 1'b0;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(negedge clock);
      check("abort_issue0_rd_en", 32'(rd_en), 32'd1);
      @(posedge clock);
      #1;
      resetn = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         check("abort_no_valid", 32'(result_valid), 32'd0);
         check("abort_idle_busy", 32'(busy), 32'd0);
         check("abort_idle_rd_en", 32'(rd_en), 32'd0);
      end
   endtask

   initial begin
      resetn       = 1'b0;
      start        = 1'b0;
      len          = '0;
      base_a       = '0;
      base_b       = '0;
      negate       = 1'b0;
      result_ready = 1'b0;
      for (int i = 0; i < 512; i++) begin
         mem_a[i] = 32'd0;
         mem_b[i] = 32'd0;
      end
      mem_a[0] = 32'd1;  mem_a[1] = 32'd2;  mem_a[2] = 32'd3;  mem_a[3] = 32'd4;
      mem_b[0] = 32'd5;  mem_b[1] = 32'd6;  mem_b[2] = 32'd7;  mem_b[3] = 32'd8;
      mem_a[510] = 32'd10;
      mem_a[511] = 32'd11;
      mem_a[100] = 32'd3;
      mem_a[101] = -32'sd4;
      mem_b[100] = 32'd2;
      mem_b[101] = 32'd2;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset");
      resetn = 1'b1;

      run_job(4, 9'd0,   9'd0,   1'b0, 32'd70,        0, 1'b0);
      run_job(4, 9'd0,   9'd0,   1'b1, 32'hFFFF_FFBA, 0, 1'b0);
      run_job(0, 9'd0,   9'd0,   1'b0, 32'd0,         0, 1'b0);
      run_job(3, 9'd510, 9'd0,   1'b0, 32'd123,       1, 1'b0);
      run_job(4, 9'd0,   9'd0,   1'b0, 32'd70,        5, 1'b1);
      run_job(4, 9'd0,   9'd0,   1'b1, 32'hFFFF_FFBA, 0, 1'b0);
      reset_mid_job();
      run_job(2, 9'd100, 9'd100, 1'b0, 32'hFFFF_FFFE, 0, 1'b0);

      repeat (2) @(negedge clock);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
